qpsk_bit_pairer: RTL and testbench
==================================

// Module: qpsk_bit_pairer
// PURPOSE
//   Upstream feeder for the QPSK modulator. Takes the serial encoded bit stream one bit at a time,
//   groups consecutive bits into (odd, even) pairs and buffers them in a FIFO. Each popped pair
//   drives the modulator's odd/even bit inputs. Odd-length frames are padded to a whole symbol.
//   Valid/ready handshakes on both sides decouple the encoder rate from the modulator/DAC rate.
// PARAMETERS
//   FIFO_DEPTH  4     pair-FIFO entries; power of 2, >= 2
//   PAD_BIT     1'b0  even bit inserted when a frame ends on an odd bit
// PORTS
//   clk         in   1   single clock, all logic on rising edge
//   rst_n       in   1   asynchronous reset, active low
//   in_bit      in   1   encoded bit
//   in_valid    in   1   in_bit/in_last valid this cycle
//   in_last     in   1   in_bit is the final bit of the frame
//   in_ready    out  1   block accepts a bit this cycle (= FIFO not full)
//   out_odd     out  1   first bit of pair (real axis of modulator)
//   out_even    out  1   second bit of pair (imaginary axis of modulator)
//   out_valid   out  1   head pair valid (= FIFO not empty)
//   out_last    out  1   head pair ends the frame
//   out_padded  out  1   head pair's even bit is PAD_BIT, not data
//   out_ready   in   1   downstream consumes head pair this cycle
//   fifo_count  out  $clog2(FIFO_DEPTH)+1   pairs currently stored, 0..FIFO_DEPTH
// BEHAVIOUR
//   Handshakes
//   - Input accept: in_valid & in_ready. Pop: out_valid & out_ready.
//   - in_ready = (fifo_count != FIFO_DEPTH). It is combinational from registered count only.
//   - Inputs are ignored while in_ready = 0. The upstream holds in_bit/in_last until accepted.
//   Pair assembler FSM
//   - S_FIRST: on accept, store in_bit as odd.
//     - in_last=0 -> S_SECOND.
//     - in_last=1 -> push {odd=in_bit, even=PAD_BIT, last=1, padded=1}; stay in S_FIRST.
//   - S_SECOND: on accept, push {odd=held, even=in_bit, last=in_last, padded=0}; -> S_FIRST.
//   - No accept: state and held bit are retained indefinitely, including across in_valid gaps.
//   FIFO
//   - First-word fall-through. A pair pushed on edge t is visible at out_* after edge t.
//     Latency is 1 cycle from accepting the completing bit to out_valid.
//   - Push and pop in the same cycle: count unchanged. The pushed entry stays in order behind the head.
//   - Pointers are $clog2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH. count tracks full vs empty.
//   - Push is impossible when full, because in_ready=0. No overflow path exists.
//   - Pop is impossible when empty, because out_valid=0. No underflow path exists.
//   - out_odd/out_even/out_last/out_padded are forced to 0 whenever out_valid=0.
//   Reset (rst_n low, any time, mid-pair or mid-frame)
//   - state=S_FIRST, held bit=0, pointers=0, fifo_count=0.
//   - out_valid=0, out_odd=0, out_even=0, out_last=0, out_padded=0.
//   - in_ready=1 once the count reads 0. A half-assembled pair and all stored pairs are discarded.
//   - Release is synchronous to clk through the usual deassertion path. The first accept is allowed on the first edge after release.
//   Frames: in_last only affects the out_last/out_padded tagging. No other frame state is kept.
// TESTING
//   1 Bits 1,0,1,1 (last on 4th), out_ready=1
//     -> pairs (1,0) then (1,1) with out_last=1.
//     -> out_valid rises 1 cycle after the 2nd and 4th accepts.
//   2 Bits 0,1,1 (last on 3rd), PAD_BIT=0
//     -> (0,1) then (1,0) with out_last=1, out_padded=1.
//   3 out_ready=0, stream 10 bits with in_valid=1, DEPTH=4
//     -> exactly 8 bits accepted, fifo_count=4, in_ready=0.
//     -> raise out_ready: 4 pairs in original order, then the remaining bits are accepted.
//   4 count=3 (DEPTH 4): simultaneous push and pop
//     -> count stays 3, head advances, new pair at tail. Also check the wrap of both pointers past entry 3.
//   5 Accept bit 1 (S_SECOND), pulse rst_n low mid-cycle, release, then send 0,1
//     -> single pair (0,1). No output or count change from the pre-reset bit.
//   6 Odd bit accepted, then in_valid=0 for 5 cycles, then even bit
//     -> one correct pair, out_valid stays 0 during the gap.

Source files
------------

// File: rtl/qpsk_bit_pairer.sv
// Small first-word fall-through FIFO used for the pair buffer.
// Latency: a word written on edge t is visible at rd_dat after edge t.
// Backpressure: full blocks writes, empty blocks reads; illegal requests are ignored.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_vld,
    input  logic [WIDTH-1:0]           wr_dat,
    input  logic                       rd_rdy,
    output logic                       rd_vld,
    output logic [WIDTH-1:0]           rd_dat,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push;
    logic             pop;

    // Status is derived from the registered count only, so ready/valid never
    // depend combinationally on the opposite side's request.
    assign full   = (count == DEPTH_C);
    assign rd_vld = (count != '0);
    assign push   = wr_vld & ~full;
    assign pop    = rd_rdy & rd_vld;
    assign rd_dat = mem[rd_ptr];

    // Storage write; contents need no reset because rd_vld qualifies them.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_dat;
        end
    end

    // Pointers wrap naturally modulo DEPTH (power of two); count tells full from empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// Groups a serial encoded bit stream into (odd, even) QPSK symbol pairs, padding odd frames.
// Latency: 1 cycle from accepting the pair-completing bit to out_valid (FWFT buffer).
// Backpressure: in_ready drops when the pair FIFO is full; out_ready pops the head pair.
module qpsk_bit_pairer #(
    parameter int   FIFO_DEPTH = 4,
    parameter logic PAD_BIT    = 1'b0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_bit,
    input  logic                          in_valid,
    input  logic                          in_last,
    output logic                          in_ready,
    output logic                          out_odd,
    output logic                          out_even,
    output logic                          out_valid,
    output logic                          out_last,
    output logic                          out_padded,
    input  logic                          out_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    typedef struct packed {
        logic odd;
        logic even;
        logic last;
        logic padded;
    } pair_t;

    typedef enum logic {
        S_FIRST  = 1'b0,
        S_SECOND = 1'b1
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   held_bit;
    logic   held_bit_nxt;
    logic   accept;
    logic   push_vld;
    pair_t  push_dat;
    pair_t  head_dat;
    logic   head_vld;
    logic   fifo_full;

    assign in_ready = ~fifo_full;
    assign accept   = in_valid & in_ready;

    // Assembler state and the held odd bit; both survive idle gaps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_FIRST;
            held_bit <= 1'b0;
        end else begin
            state    <= state_nxt;
            held_bit <= held_bit_nxt;
        end
    end

    // Next-state and push generation: a pair is pushed on the second bit, or
    // immediately with a pad bit when a frame ends on the first bit.
    always_comb begin
        state_nxt    = state;
        held_bit_nxt = held_bit;
        push_vld     = 1'b0;
        push_dat     = '0;
        if (accept) begin
            case (state)
                S_FIRST: begin
                    held_bit_nxt = in_bit;
                    if (in_last) begin
                        push_vld        = 1'b1;
                        push_dat.odd    = in_bit;
                        push_dat.even   = PAD_BIT;
                        push_dat.last   = 1'b1;
                        push_dat.padded = 1'b1;
                    end else begin
                        state_nxt = S_SECOND;
                    end
                end
                S_SECOND: begin
                    push_vld        = 1'b1;
                    push_dat.odd    = held_bit;
                    push_dat.even   = in_bit;
                    push_dat.last   = in_last;
                    push_dat.padded = 1'b0;
                    state_nxt       = S_FIRST;
                end
                default: begin
                    state_nxt = S_FIRST;
                end
            endcase
        end
    end

    sync_fifo #(
        .WIDTH ($bits(pair_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_pair_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .wr_vld (push_vld),
        .wr_dat (push_dat),
        .rd_rdy (out_ready),
        .rd_vld (head_vld),
        .rd_dat (head_dat),
        .full   (fifo_full),
        .count  (fifo_count)
    );

    // Head fields are masked so stale storage never leaks when the FIFO is empty.
    assign out_valid  = head_vld;
    assign out_odd    = head_vld & head_dat.odd;
    assign out_even   = head_vld & head_dat.even;
    assign out_last   = head_vld & head_dat.last;
    assign out_padded = head_vld & head_dat.padded;
endmodule

// File: tb/tb_qpsk_bit_pairer.sv
module tb_qpsk_bit_pairer;
    logic       clk;
    logic       rst_n;
    logic       in_bit;
    logic       in_valid;
    logic       in_last;
    logic       in_ready;
    logic       out_odd;
    logic       out_even;
    logic       out_valid;
    logic       out_last;
    logic       out_padded;
    logic       out_ready;
    logic [2:0] fifo_count;

    int errors = 0;
    int checks = 0;

    qpsk_bit_pairer #(.FIFO_DEPTH(4), .PAD_BIT(1'b0)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_bit     (in_bit),
        .in_valid   (in_valid),
        .in_last    (in_last),
        .in_ready   (in_ready),
        .out_odd    (out_odd),
        .out_even   (out_even),
        .out_valid  (out_valid),
        .out_last   (out_last),
        .out_padded (out_padded),
        .out_ready  (out_ready),
        .fifo_count (fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Head pair as {valid, odd, even, last, padded}
    task automatic chk_head(input string tag, input logic [4:0] exp);
        chk(tag, {3'b0, out_valid, out_odd, out_even, out_last, out_padded}, {3'b0, exp});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one bit for exactly one cycle (in_ready is known to be 1 here).
    task automatic send(input logic b, input logic l, input logic ordy);
        in_valid  = 1'b1;
        in_bit    = b;
        in_last   = l;
        out_ready = ordy;
        step();
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b0;
    endtask

    initial begin
        logic [9:0] pat;
        int         idx;
        logic       acc;

        rst_n = 1'b0; in_bit = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        // Reset state
        chk_head("reset_head", 5'b0_0000);
        chk("reset_count", {5'b0, fifo_count}, 8'd0);
        chk("reset_in_ready", {7'b0, in_ready}, 8'd1);
        rst_n = 1'b1;

        // T1: 1,0,1,1(last), out_ready=1
        send(1'b1, 1'b0, 1'b1);
        chk_head("t1_after_b1", 5'b0_0000);
        send(1'b0, 1'b0, 1'b1);
        chk_head("t1_pair0", 5'b1_1000);
        chk("t1_count1", {5'b0, fifo_count}, 8'd1);
        send(1'b1, 1'b0, 1'b1);
        chk_head("t1_after_b3", 5'b0_0000);
        chk("t1_count0", {5'b0, fifo_count}, 8'd0);
        send(1'b1, 1'b1, 1'b1);
        chk_head("t1_pair1", 5'b1_1110);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk_head("t1_drained", 5'b0_0000);

        // T2: 0,1,1(last) -> (0,1) then padded (1,0)
        send(1'b0, 1'b0, 1'b0);
        send(1'b1, 1'b0, 1'b0);
        send(1'b1, 1'b1, 1'b0);
        chk("t2_count", {5'b0, fifo_count}, 8'd2);
        chk_head("t2_pair0", 5'b1_0100);
        out_ready = 1'b1;
        step();
        chk_head("t2_pair1_pad", 5'b1_1011);
        step();
        out_ready = 1'b0;
        chk_head("t2_drained", 5'b0_0000);

        // T3: fill with out_ready=0 from a 10-bit stream
        pat = 10'b11_0100_1011; // bit i sent i-th: 1,1,0,1,0,0,1,0,1,1
        idx = 0;
        in_valid = 1'b1; in_last = 1'b0; in_bit = pat[0];
        for (int c = 0; c < 12; c++) begin
            acc = in_valid & in_ready;
            step();
            if (acc) idx++;
            in_valid = (idx < 10);
            in_bit   = (idx < 10) ? pat[idx] : 1'b0;
        end
        chk("t3_accepted", idx[7:0], 8'd8);
        chk("t3_count_full", {5'b0, fifo_count}, 8'd4);
        chk("t3_in_ready", {7'b0, in_ready}, 8'd0);
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            case (k)
                0: chk_head("t3_pop0", 5'b1_1100);
                1: chk_head("t3_pop1", 5'b1_0100);
                2: chk_head("t3_pop2", 5'b1_0000);
                default: chk_head("t3_pop3", 5'b1_1000);
            endcase
            acc = in_valid & in_ready;
            step();
            if (acc) idx++;
            in_valid = (idx < 10);
            in_bit   = (idx < 10) ? pat[idx] : 1'b0;
        end
        chk("t3_all_accepted", idx[7:0], 8'd10);
        chk("t3_count_after", {5'b0, fifo_count}, 8'd1);
        chk_head("t3_tail_pair", 5'b1_1100);
        step();
        out_ready = 1'b0;
        in_valid  = 1'b0;
        chk("t3_empty", {5'b0, fifo_count}, 8'd0);

        // T4: count=3, simultaneous push/pop with pointer wrap
        send(1'b1, 1'b0, 1'b0); send(1'b0, 1'b0, 1'b0); // P1 (1,0)
        send(1'b0, 1'b0, 1'b0); send(1'b1, 1'b0, 1'b0); // P2 (0,1)
        send(1'b1, 1'b0, 1'b0); send(1'b1, 1'b0, 1'b0); // P3 (1,1)
        chk("t4_count3", {5'b0, fifo_count}, 8'd3);
        chk_head("t4_head_p1", 5'b1_1000);
        send(1'b0, 1'b0, 1'b0); send(1'b0, 1'b0, 1'b1); // P4 (0,0) pushed, P1 popped
        chk("t4_count_pp1", {5'b0, fifo_count}, 8'd3);
        chk_head("t4_head_p2", 5'b1_0100);
        send(1'b1, 1'b0, 1'b0); send(1'b0, 1'b0, 1'b1); // P5 (1,0)
        chk("t4_count_pp2", {5'b0, fifo_count}, 8'd3);
        chk_head("t4_head_p3", 5'b1_1100);
        send(1'b0, 1'b0, 1'b0); send(1'b1, 1'b1, 1'b1); // P6 (0,1,last)
        chk("t4_count_pp3", {5'b0, fifo_count}, 8'd3);
        chk_head("t4_head_p4", 5'b1_0000);
        out_ready = 1'b1;
        step();
        chk_head("t4_head_p5", 5'b1_1000);
        step();
        chk_head("t4_head_p6", 5'b1_0110);
        step();
        out_ready = 1'b0;
        chk_head("t4_drained", 5'b0_0000);

        // T5: reset mid-pair with a stored pair, then 0,1
        send(1'b1, 1'b0, 1'b0); send(1'b1, 1'b0, 1'b0);
        send(1'b1, 1'b0, 1'b0);
        chk("t5_pre_count", {5'b0, fifo_count}, 8'd1);
        rst_n = 1'b0;
        #2;
        chk("t5_rst_count", {5'b0, fifo_count}, 8'd0);
        chk_head("t5_rst_head", 5'b0_0000);
        chk("t5_rst_in_ready", {7'b0, in_ready}, 8'd1);
        #2;
        rst_n = 1'b1;
        send(1'b0, 1'b0, 1'b0);
        chk_head("t5_after_b0", 5'b0_0000);
        send(1'b1, 1'b0, 1'b0);
        chk_head("t5_pair", 5'b1_0100);
        chk("t5_count", {5'b0, fifo_count}, 8'd1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // T6: odd bit, 5-cycle in_valid gap, then even bit
        send(1'b1, 1'b0, 1'b0);
        for (int g = 0; g < 5; g++) begin
            step();
            chk("t6_gap_valid", {7'b0, out_valid}, 8'd0);
        end
        send(1'b0, 1'b1, 1'b0);
        chk_head("t6_pair", 5'b1_1010);
        chk("t6_count", {5'b0, fifo_count}, 8'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
